// File: rtl/axi_burst_ram_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_burst_ram_if
//  Purpose  : AXI-style burst bus bundle (AW/W/B/AR/R channels) used between
//             a bus master and the axi_burst_ram slave.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_burst_ram_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic [1:0]                AWBURST;
    logic [7:0]                AWLEN;
    // Write data channel
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      WLAST;
    // Write response channel
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    // Read address channel
    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic [1:0]                ARBURST;
    logic [7:0]                ARLEN;
    // Read data channel
    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;

    modport slave (
        input  AWVALID, AWADDR, AWBURST, AWLEN,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST,
        output WREADY,
        output BVALID, BRESP,
        input  BREADY,
        input  ARVALID, ARADDR, ARBURST, ARLEN,
        output ARREADY,
        output RVALID, RDATA, RRESP, RLAST,
        input  RREADY
    );

    modport master (
        output AWVALID, AWADDR, AWBURST, AWLEN,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST,
        input  WREADY,
        input  BVALID, BRESP,
        output BREADY,
        output ARVALID, ARADDR, ARBURST, ARLEN,
        input  ARREADY,
        input  RVALID, RDATA, RRESP, RLAST,
        output RREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi_burst_ram.sv
`default_nettype none
// ============================================================================
//  Module   : axi_burst_ram
//  Purpose  : Word-addressed burst RAM slave with independent write and read
//             state machines, byte strobes and FIXED/INCR(/WRAP) bursts.
//  Config   : define AXI_BURST_RAM_WRAP_EN to support WRAP bursts; otherwise
//             burst type 2'b10 is treated as reserved (SLVERR, no access).
//  Revision : 1.0  initial release
// ============================================================================
module axi_burst_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  wire logic        ACLK,
    input  wire logic        ARESETn,
    axi_burst_ram_if.slave   s_axi
);
    localparam int                  STRB_W  = DATA_WIDTH / 8;
    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1}                r_state_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Reserved burst type, or WRAP with a window that is not a power of two.
    function automatic logic burst_illegal(input logic [1:0] b, input logic [7:0] len);
`ifdef AXI_BURST_RAM_WRAP_EN
        return (b == 2'b11) ||
               ((b == 2'b10) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
`else
        return (b == 2'b11) || (b == 2'b10);
`endif
    endfunction

    // WRAP keeps the upper bits and increments only inside the (len+1) window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0] b,
                                                        input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] mask;
        mask = ADDR_WIDTH'(len);
        case (b)
            2'b01:   return a + ADDR_WIDTH'(1);
            2'b10:   return (a & ~mask) | ((a + ADDR_WIDTH'(1)) & mask);
            default: return a;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    // Ready outputs stay low until the first clock edge after reset release.
    logic live_q, live_d;

    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic                  werr_q, werr_d, will_q, will_d;
    logic                  mem_we;

    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rd_addr;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
    logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic                  rill_q, rill_d, rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;

    // Write path: address capture, per-beat strobed writes, error tracking.
    always_comb begin
        live_d    = 1'b1;
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wburst_d  = wburst_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        will_d    = will_q;
        mem_we    = 1'b0;
        s_axi.AWREADY = live_q && (w_state_q == W_IDLE);
        s_axi.WREADY  = (w_state_q == W_DATA);
        s_axi.BVALID  = (w_state_q == W_RESP);
        s_axi.BRESP   = ((w_state_q == W_RESP) && werr_q) ? 2'b10 : 2'b00;
        case (w_state_q)
            W_IDLE: if (s_axi.AWREADY && s_axi.AWVALID) begin
                waddr_d   = s_axi.AWADDR;
                wburst_d  = s_axi.AWBURST;
                wlen_d    = s_axi.AWLEN;
                wbeat_d   = 8'd0;
                will_d    = burst_illegal(s_axi.AWBURST, s_axi.AWLEN);
                werr_d    = burst_illegal(s_axi.AWBURST, s_axi.AWLEN);
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi.WVALID) begin
                if (!will_q && in_range(waddr_q)) mem_we = 1'b1;
                else                              werr_d = 1'b1;
                waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
                wbeat_d = wbeat_q + 8'd1;
                if (wbeat_q == wlen_q) begin
                    w_state_d = W_RESP;
                    if (!s_axi.WLAST) werr_d = 1'b1;
                end else if (s_axi.WLAST) begin
                    w_state_d = W_RESP;
                    werr_d    = 1'b1;
                end
            end
            W_RESP: if (s_axi.BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write path and ready-enable state registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wburst_q  <= 2'b00;
            wlen_q    <= 8'd0;
            wbeat_q   <= 8'd0;
            werr_q    <= 1'b0;
            will_q    <= 1'b0;
        end else begin
            live_q    <= live_d;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wburst_q  <= wburst_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            will_q    <= will_d;
        end
    end

    // RAM array: byte-strobed write port, never reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.WSTRB[b]) mem[waddr_q[IDX_W-1:0]][b*8 +: 8] <= s_axi.WDATA[b*8 +: 8];
            end
        end
    end

    // Read path: fetch the next beat's word so it is registered on the handshake
    // edge; the array write lands on the same edge, so a collision reads old data.
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rburst_d  = rburst_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rill_d    = rill_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_addr   = (r_state_q == R_IDLE) ? s_axi.ARADDR : next_addr(raddr_q, rburst_q, rlen_q);
        rd_word   = mem[rd_addr[IDX_W-1:0]];
        s_axi.ARREADY = live_q && (r_state_q == R_IDLE);
        s_axi.RVALID  = (r_state_q == R_DATA);
        s_axi.RDATA   = rdata_q;
        s_axi.RRESP   = rresp_q;
        s_axi.RLAST   = rlast_q;
        case (r_state_q)
            R_IDLE: if (s_axi.ARREADY && s_axi.ARVALID) begin
                raddr_d   = s_axi.ARADDR;
                rburst_d  = s_axi.ARBURST;
                rlen_d    = s_axi.ARLEN;
                rbeat_d   = 8'd0;
                rill_d    = burst_illegal(s_axi.ARBURST, s_axi.ARLEN);
                rlast_d   = (s_axi.ARLEN == 8'd0);
                if (burst_illegal(s_axi.ARBURST, s_axi.ARLEN) || !in_range(rd_addr)) begin
                    rdata_d = '0;
                    rresp_d = 2'b10;
                end else begin
                    rdata_d = rd_word;
                    rresp_d = 2'b00;
                end
                r_state_d = R_DATA;
            end
            R_DATA: if (s_axi.RREADY) begin
                if (rlast_q) begin
                    rdata_d   = '0;
                    rresp_d   = 2'b00;
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    raddr_d = rd_addr;
                    rbeat_d = rbeat_q + 8'd1;
                    rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                    if (rill_q || !in_range(rd_addr)) begin
                        rdata_d = '0;
                        rresp_d = 2'b10;
                    end else begin
                        rdata_d = rd_word;
                        rresp_d = 2'b00;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read path state and output registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rburst_q  <= 2'b00;
            rlen_q    <= 8'd0;
            rbeat_q   <= 8'd0;
            rill_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rburst_q  <= rburst_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rill_q    <= rill_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_burst_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_burst_ram
//  Purpose  : Directed self-checking bench for axi_burst_ram (default
//             parameters); WRAP expectations follow AXI_BURST_RAM_WRAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_burst_ram;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_burst_ram_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    axi_burst_ram #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(1024)) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .s_axi   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] wd [0:15];
    logic [31:0] rd [0:15];
    logic [1:0]  rr [0:15];
    logic        rl [0:15];
    logic [1:0]  resp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst: nbeats data beats, WLAST asserted on beat last_idx (-1 = never).
    task automatic do_write(input logic [15:0] addr, input logic [1:0] burst, input logic [7:0] len,
                            input int nbeats, input int last_idx, input logic [3:0] strb,
                            output logic [1:0] bresp);
        int t;
        bus.AWVALID = 1'b1; bus.AWADDR = addr; bus.AWBURST = burst; bus.AWLEN = len;
        t = 0;
        while (!bus.AWREADY && t < TMO) begin tick(); t++; end
        if (t >= TMO) check_val("aw_timeout", 1, 0);
        tick();
        bus.AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.WVALID = 1'b1; bus.WDATA = wd[i]; bus.WSTRB = strb; bus.WLAST = (i == last_idx);
            t = 0;
            while (!bus.WREADY && t < TMO) begin tick(); t++; end
            if (t >= TMO) check_val("w_timeout", 1, 0);
            tick();
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        bus.BREADY = 1'b1;
        t = 0;
        while (!bus.BVALID && t < TMO) begin tick(); t++; end
        if (t >= TMO) check_val("b_timeout", 1, 0);
        bresp = bus.BRESP;
        tick();
        bus.BREADY = 1'b0;
    endtask

    // Read burst into rd/rr/rl; beat stall_beat is held off for stall_n cycles
    // while RDATA must stay at stall_exp.
    task automatic do_read(input logic [15:0] addr, input logic [1:0] burst, input logic [7:0] len,
                           input int stall_beat, input int stall_n, input logic [31:0] stall_exp);
        int t;
        bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARBURST = burst; bus.ARLEN = len;
        t = 0;
        while (!bus.ARREADY && t < TMO) begin tick(); t++; end
        if (t >= TMO) check_val("ar_timeout", 1, 0);
        tick();
        bus.ARVALID = 1'b0;
        check_val("r_latency1", bus.RVALID, 1);
        bus.RREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!bus.RVALID && t < TMO) begin tick(); t++; end
            if (t >= TMO) check_val("r_timeout", 1, 0);
            rd[i] = bus.RDATA; rr[i] = bus.RRESP; rl[i] = bus.RLAST;
            if (i == stall_beat) begin
                bus.RREADY = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    check_val("r_hold_valid", bus.RVALID, 1);
                    check_val("r_hold_data", bus.RDATA, stall_exp);
                end
                bus.RREADY = 1'b1;
            end
            tick();
        end
        bus.RREADY = 1'b0;
    endtask

    initial begin
        bus.AWVALID = 0; bus.AWADDR = '0; bus.AWBURST = 0; bus.AWLEN = 0;
        bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = 0; bus.WLAST = 0; bus.BREADY = 0;
        bus.ARVALID = 0; bus.ARADDR = '0; bus.ARBURST = 0; bus.ARLEN = 0; bus.RREADY = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_awready", bus.AWREADY, 0);
        check_val("rst_arready", bus.ARREADY, 0);
        check_val("rst_wready", bus.WREADY, 0);
        check_val("rst_bvalid", bus.BVALID, 0);
        check_val("rst_rvalid", bus.RVALID, 0);
        check_val("rst_rdata", bus.RDATA, 0);
        check_val("rst_rresp", bus.RRESP, 0);
        check_val("rst_rlast", bus.RLAST, 0);
        rst_n = 1'b1;
        tick();
        check_val("rel_awready", bus.AWREADY, 1);
        check_val("rel_arready", bus.ARREADY, 1);

        // INCR write/read of four beats
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        do_write(16'h0010, 2'b01, 8'd3, 4, 3, 4'hF, resp);
        check_val("incr_bresp", resp, 2'b00);
        do_read(16'h0010, 2'b01, 8'd3, -1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check_val("incr_rdata", rd[i], 32'hA0 + i);
            check_val("incr_rresp", rr[i], 2'b00);
            check_val("incr_rlast", rl[i], (i == 3));
        end
        check_val("idle_rvalid", bus.RVALID, 0);
        check_val("idle_rdata", bus.RDATA, 0);

        // Byte strobes
        wd[0] = 32'h11223344;
        do_write(16'h0020, 2'b01, 8'd0, 1, 0, 4'hF, resp);
        wd[0] = 32'hFFFFFFFF;
        do_write(16'h0020, 2'b01, 8'd0, 1, 0, 4'h5, resp);
        check_val("strb_bresp", resp, 2'b00);
        do_read(16'h0020, 2'b01, 8'd0, -1, 0, 0);
        check_val("strb_rdata", rd[0], 32'h11FF33FF);
        check_val("strb_rlast", rl[0], 1);

        // FIXED burst: every beat lands on the same word, last one wins
        wd[0] = 32'h0F0; wd[1] = 32'h0F1; wd[2] = 32'h0F2;
        do_write(16'h0040, 2'b00, 8'd2, 3, 2, 4'hF, resp);
        do_read(16'h0040, 2'b00, 8'd1, -1, 0, 0);
        check_val("fixed_rdata0", rd[0], 32'h0F2);
        check_val("fixed_rdata1", rd[1], 32'h0F2);

        // WRAP burst (or reserved burst type without the macro)
        wd[0] = 32'h100; wd[1] = 32'h101; wd[2] = 32'h102; wd[3] = 32'h103;
        do_write(16'h0004, 2'b01, 8'd3, 4, 3, 4'hF, resp);
        wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
        do_write(16'h0006, 2'b10, 8'd3, 4, 3, 4'hF, resp);
        do_read(16'h0004, 2'b01, 8'd3, -1, 0, 0);
`ifdef AXI_BURST_RAM_WRAP_EN
        check_val("wrap_bresp", resp, 2'b00);
        check_val("wrap_m4", rd[0], 32'hB2);
        check_val("wrap_m5", rd[1], 32'hB3);
        check_val("wrap_m6", rd[2], 32'hB0);
        check_val("wrap_m7", rd[3], 32'hB1);
        do_read(16'h0006, 2'b10, 8'd3, -1, 0, 0);
        check_val("wrap_rd0", rd[0], 32'hB0);
        check_val("wrap_rd2", rd[2], 32'hB2);
        check_val("wrap_rresp", rr[3], 2'b00);
        // WRAP with a non power-of-two window is illegal even when enabled
        do_write(16'h0006, 2'b10, 8'd2, 3, 2, 4'hF, resp);
        check_val("wrap_len2_bresp", resp, 2'b10);
`else
        check_val("wrap_bresp", resp, 2'b10);
        check_val("wrap_m4", rd[0], 32'h100);
        check_val("wrap_m5", rd[1], 32'h101);
        check_val("wrap_m6", rd[2], 32'h102);
        check_val("wrap_m7", rd[3], 32'h103);
        do_read(16'h0006, 2'b10, 8'd3, -1, 0, 0);
        check_val("wrap_rd0", rd[0], 32'h0);
        check_val("wrap_rd2", rd[2], 32'h0);
        check_val("wrap_rresp", rr[3], 2'b10);
`endif
        check_val("wrap_rlast", rl[3], 1);

        // Burst type 11 is always illegal
        do_read(16'h0010, 2'b11, 8'd1, -1, 0, 0);
        check_val("b11_rdata", rd[0], 0);
        check_val("b11_rresp", rr[1], 2'b10);

        // Out-of-range read tail
        wd[0] = 32'hC0; wd[1] = 32'hC1;
        do_write(16'd1022, 2'b01, 8'd1, 2, 1, 4'hF, resp);
        do_read(16'd1022, 2'b01, 8'd3, -1, 0, 0);
        check_val("oor_d0", rd[0], 32'hC0);
        check_val("oor_r0", rr[0], 2'b00);
        check_val("oor_d1", rd[1], 32'hC1);
        check_val("oor_r1", rr[1], 2'b00);
        check_val("oor_d2", rd[2], 0);
        check_val("oor_r2", rr[2], 2'b10);
        check_val("oor_d3", rd[3], 0);
        check_val("oor_r3", rr[3], 2'b10);
        check_val("oor_l3", rl[3], 1);
        do_write(16'd1023, 2'b01, 8'd1, 2, 1, 4'hF, resp);
        check_val("oor_bresp", resp, 2'b10);

        // WLAST protocol errors: early, then missing
        do_write(16'h0050, 2'b01, 8'd3, 2, 1, 4'hF, resp);
        check_val("early_wlast_bresp", resp, 2'b10);
        do_write(16'h0050, 2'b01, 8'd1, 2, -1, 4'hF, resp);
        check_val("miss_wlast_bresp", resp, 2'b10);
        check_val("after_err_awready", bus.AWREADY, 1);

        // Read back-pressure holds the beat
        do_read(16'h0010, 2'b01, 8'd3, 1, 3, 32'hA1);
        check_val("stall_rd1", rd[1], 32'hA1);
        check_val("stall_rd2", rd[2], 32'hA2);

        // Same-cycle write and read of one word returns old data
        wd[0] = 32'h5A5A0001;
        do_write(16'h0030, 2'b01, 8'd0, 1, 0, 4'hF, resp);
        bus.AWVALID = 1'b1; bus.AWADDR = 16'h0030; bus.AWBURST = 2'b01; bus.AWLEN = 8'd0;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WDATA = 32'hDEAD0002; bus.WSTRB = 4'hF; bus.WLAST = 1'b1;
        bus.ARVALID = 1'b1; bus.ARADDR = 16'h0030; bus.ARBURST = 2'b01; bus.ARLEN = 8'd0;
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.ARVALID = 1'b0;
        check_val("coll_rvalid", bus.RVALID, 1);
        check_val("coll_rdata_old", bus.RDATA, 32'h5A5A0001);
        check_val("coll_bvalid", bus.BVALID, 1);
        bus.RREADY = 1'b1; bus.BREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0; bus.BREADY = 1'b0;
        do_read(16'h0030, 2'b01, 8'd0, -1, 0, 0);
        check_val("coll_rdata_new", rd[0], 32'hDEAD0002);

        // Reset in the middle of a write burst
        bus.AWVALID = 1'b1; bus.AWADDR = 16'h0200; bus.AWBURST = 2'b01; bus.AWLEN = 8'd3;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WLAST = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_wready", bus.WREADY, 0);
        check_val("mid_rst_awready", bus.AWREADY, 0);
        check_val("mid_rst_bvalid", bus.BVALID, 0);
        check_val("mid_rst_arready", bus.ARREADY, 0);
        bus.WVALID = 1'b0;
        tick();
        tick();
        check_val("mid_rst_bvalid2", bus.BVALID, 0);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_awready", bus.AWREADY, 1);
        check_val("post_rst_bvalid", bus.BVALID, 0);
        do_read(16'h0010, 2'b01, 8'd3, -1, 0, 0);
        check_val("ram_kept0", rd[0], 32'hA0);
        check_val("ram_kept3", rd[3], 32'hA3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_burst_ram.md
AXI_BURST_RAM -- requirements
Module: axi_burst_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 1024, RAM size in words (DEPTH <= 2^ADDR_WIDTH).
REQ-004 SHALL have port ACLK  input  1  clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port ARESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have AWVALID input 1, AWREADY output 1, AWADDR input ADDR_WIDTH (word address), AWBURST input 2, AWLEN input 8 (beats-1): write-address channel.
REQ-007 SHALL have WVALID input 1, WREADY output 1, WDATA input DATA_WIDTH, WSTRB input DATA_WIDTH/8 (byte enables), WLAST input 1: write-data channel.
REQ-008 SHALL have BVALID output 1, BREADY input 1, BRESP output 2: write-response channel.
REQ-009 SHALL have ARVALID input 1, ARREADY output 1, ARADDR input ADDR_WIDTH, ARBURST input 2, ARLEN input 8: read-address channel.
REQ-010 SHALL have RVALID output 1, RREADY input 1, RDATA output DATA_WIDTH, RRESP output 2, RLAST output 1: read-data channel.

Function
REQ-011 Write and read paths SHALL be independent FSMs: write W_IDLE->W_DATA->W_RESP->W_IDLE; read R_IDLE->R_DATA->R_IDLE.
REQ-012 AWREADY SHALL be 1 exactly in W_IDLE; AW handshake latches AWADDR/AWBURST/AWLEN, clears beat counter and error flag, enters W_DATA.
REQ-013 WREADY SHALL be 1 exactly in W_DATA; each W handshake writes only bytes with WSTRB set, at current beat address, if address < DEPTH; else no write, error flag set.
REQ-014 Beat address SHALL advance per handshake: FIXED (00) unchanged; INCR (01) +1 modulo 2^ADDR_WIDTH; WRAP (10) +1 within the (LEN+1)-word window aligned to (LEN+1).
REQ-015 WRAP with LEN not in {1,3,7,15}, or burst 11, SHALL be illegal: no RAM writes / RDATA 0, SLVERR for whole burst.
REQ-016 Write burst SHALL end on beat LEN; WLAST on any earlier beat also ends it with SLVERR; missing WLAST on beat LEN SHALL set SLVERR.
REQ-017 W_RESP: BVALID=1 held until BREADY; BRESP 00 OKAY or 10 SLVERR; after B handshake -> W_IDLE.
REQ-018 ARREADY SHALL be 1 exactly in R_IDLE; AR handshake latches fields, enters R_DATA; first RVALID the next cycle (latency 1).
REQ-019 RDATA/RRESP/RLAST SHALL be held stable while RVALID=1 and RREADY=0; next beat presented the cycle after each R handshake (back-to-back at full rate).
REQ-020 Out-of-range read beat SHALL return RDATA 0, RRESP 10; others RRESP 00; RLAST=1 only on beat LEN; R handshake with RLAST -> R_IDLE.
REQ-021 Same-cycle write and read of one address SHALL return the pre-write (old) data.
REQ-022 Outputs SHALL be 0 whenever their VALID is 0 (RDATA, RRESP, RLAST, BRESP).

Reset
REQ-023 ARESETn low SHALL asynchronously force both FSMs idle and AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, RLAST to 0.
REQ-024 RAM contents SHALL NOT be reset; reset mid-burst abandons the burst with no B/R response.
REQ-025 After ARESETn rises, AWREADY and ARREADY SHALL be 1 from the first clock edge.

Configuration
REQ-026 Macro AXI_BURST_RAM_WRAP_EN defined: WRAP bursts supported per REQ-014/015.
REQ-027 Macro undefined: AWBURST/ARBURST 10 SHALL be treated as reserved (no writes, RDATA 0, SLVERR for the burst).

Verification
REQ-028 INCR write addr 0x010, LEN 3, data 0xA0..0xA3, WSTRB 0xF -> BRESP 00; INCR read same -> 0xA0..0xA3, RLAST on 4th beat.
REQ-029 Write 0x11223344 to 0x020, then WSTRB 0x5 data 0xFFFFFFFF -> read returns 0x11FF33FF.
REQ-030 WRAP write addr 0x006, LEN 3 (WRAP_EN) -> beats hit 0x006,0x007,0x004,0x005; without macro -> BRESP 10, RAM unchanged.
REQ-031 INCR read from DEPTH-2, LEN 3 -> beats 1-2 RRESP 00, beats 3-4 RDATA 0, RRESP 10.
REQ-032 RREADY held low 3 cycles on beat 2 -> RDATA stable; ARESETn pulsed mid-write burst -> all outputs 0, no BVALID, AWREADY 1 after release.
